// File: rtl/my_ws2812_pkg.sv
// rtl/my_ws2812_pkg.sv - shared sizes, GRB field positions and swap FSM states
package my_ws2812_pkg;
  localparam int N_LEDS  = 64;
  localparam int ADDR_W  = 6;
  localparam int COLOR_W = 24;

  localparam int G_HI = 23;
  localparam int G_LO = 16;
  localparam int R_HI = 15;
  localparam int R_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;
endpackage

// File: rtl/my_ws2812_fb_ram.sv
// rtl/my_ws2812_fb_ram.sv - one frame bank: simple dual-port RAM with registered read
module my_ws2812_fb_ram
  import my_ws2812_pkg::*;
#(
  parameter int DEPTH = N_LEDS,
  parameter int AW    = ADDR_W,
  parameter int WIDTH = COLOR_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/my_ws2812_fb.sv
// rtl/my_ws2812_fb.sv - double-buffered ws2812 frame buffer with frame-aligned swap and brightness scaling
module my_ws2812_fb #(
  parameter int N_LEDS = my_ws2812_pkg::N_LEDS,
  parameter int ADDR_W = my_ws2812_pkg::ADDR_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [my_ws2812_pkg::COLOR_W-1:0] wr_color,
  input  logic                              commit,
  input  logic [7:0]                        bright,
  output logic                              swap_ack,
  input  logic [ADDR_W-1:0]                 leddata_addr,
  input  logic                              leddata_start,
  output logic [my_ws2812_pkg::COLOR_W-1:0] leddata_color
);
  import my_ws2812_pkg::*;

  swap_state_t        state, state_nxt;
  logic               start_d, fetch_start, swap_now, front_sel, wr_ok;
  logic [7:0]         bright_r;
  logic               s1_valid, s1_bank, s1_oob;
  logic [ADDR_W-1:0]  s1_addr;
  logic               s2_valid, s2_bank, s2_oob;
  logic [COLOR_W-1:0] rd0, rd1, rd_sel;

  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(ch) * 16'({1'b0, b} + 9'd1);
    return 8'(prod >> 8);
  endfunction

  function automatic logic [COLOR_W-1:0] scale_grb(input logic [COLOR_W-1:0] c, input logic [7:0] b);
    return {scale_ch(c[G_HI:G_LO], b), scale_ch(c[R_HI:R_LO], b), scale_ch(c[B_HI:B_LO], b)};
  endfunction

  assign fetch_start = leddata_start && !start_d;
  assign wr_ready    = (state == SWAP_IDLE);
  assign wr_ok       = wr_valid && wr_ready && (32'(wr_addr) < N_LEDS);
  assign rd_sel      = s2_bank ? rd1 : rd0;

  always_comb begin
    state_nxt = state;
    swap_now  = 1'b0;
    case (state)
      SWAP_IDLE:    if (commit) state_nxt = SWAP_PENDING;
      SWAP_PENDING: if (fetch_start && leddata_addr == '0) begin
        swap_now  = 1'b1;
        state_nxt = SWAP_IDLE;
      end
      default:      state_nxt = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SWAP_IDLE;
      start_d       <= 1'b0;
      front_sel     <= 1'b0;
      bright_r      <= 8'hFF;
      swap_ack      <= 1'b0;
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      leddata_color <= '0;
    end else begin
      state    <= state_nxt;
      start_d  <= leddata_start;
      swap_ack <= swap_now;
      if (swap_now) begin
        front_sel <= ~front_sel;
        bright_r  <= bright;
      end
      s1_valid <= fetch_start;
      s2_valid <= s1_valid;
      if (s2_valid) leddata_color <= s2_oob ? '0 : scale_grb(rd_sel, bright_r);
    end
  end

  // The fetch that triggers a swap must already read the new front bank.
  always_ff @(posedge clk) begin
    if (fetch_start) begin
      s1_addr <= leddata_addr;
      s1_bank <= front_sel ^ swap_now;
      s1_oob  <= (32'(leddata_addr) >= N_LEDS);
    end
    s2_bank <= s1_bank;
    s2_oob  <= s1_oob;
  end

  my_ws2812_fb_ram #(.DEPTH(N_LEDS), .AW(ADDR_W), .WIDTH(COLOR_W)) u_bank0 (
    .clk   (clk),
    .we    (wr_ok && front_sel),
    .waddr (wr_addr),
    .wdata (wr_color),
    .re    (s1_valid),
    .raddr (s1_addr),
    .rdata (rd0)
  );

  my_ws2812_fb_ram #(.DEPTH(N_LEDS), .AW(ADDR_W), .WIDTH(COLOR_W)) u_bank1 (
    .clk   (clk),
    .we    (wr_ok && !front_sel),
    .waddr (wr_addr),
    .wdata (wr_color),
    .re    (s1_valid),
    .raddr (s1_addr),
    .rdata (rd1)
  );
endmodule

// File: tb/tb_my_ws2812_fb.sv
// tb/tb_my_ws2812_fb.sv - self-checking bench for my_ws2812_fb
module tb_my_ws2812_fb;
  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_addr = '0;
  logic [23:0] wr_color = '0;
  logic        commit = 1'b0;
  logic [7:0]  bright = 8'hFF;
  logic        swap_ack;
  logic [5:0]  leddata_addr = '0;
  logic        leddata_start = 1'b0;
  logic [23:0] leddata_color;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  my_ws2812_fb #(.N_LEDS(64), .ADDR_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_color      (wr_color),
    .commit        (commit),
    .bright        (bright),
    .swap_ack      (swap_ack),
    .leddata_addr  (leddata_addr),
    .leddata_start (leddata_start),
    .leddata_color (leddata_color)
  );

  function automatic logic [23:0] scaled(input logic [23:0] c, input int b);
    int g, r, bl;
    g  = (int'(c[23:16]) * (b + 1)) / 256;
    r  = (int'(c[15:8])  * (b + 1)) / 256;
    bl = (int'(c[7:0])   * (b + 1)) / 256;
    return {8'(g), 8'(r), 8'(bl)};
  endfunction

  function automatic logic [23:0] pat(input int bank, input int a);
    return {8'(a * 4 + 1), 8'(bank * 128 + a), 8'(8'hC3 ^ a)};
  endfunction

  // Frame-level model: two color arrays, a pending flag and a list of due results.
  logic [23:0] mbank [2][N];
  int          mfront = 0;
  bit          mpend = 1'b0;
  int          mbright = 255;
  bit          mprev = 1'b0;
  int          cyc = 0;
  logic [23:0] exp_color = '0;
  bit          exp_ack = 1'b0;
  bit          exp_ready = 1'b1;
  int          due_q[$];
  logic [23:0] val_q[$];

  always @(posedge clk) begin : model
    bit was_pend;
    bit fstart;
    cyc++;
    if (rst) begin
      mpend = 1'b0; mfront = 0; mbright = 255; mprev = 1'b0;
      exp_color = '0; exp_ack = 1'b0;
      due_q.delete(); val_q.delete();
    end else begin
      was_pend = mpend;
      fstart   = leddata_start && !mprev;
      exp_ack  = 1'b0;
      if (wr_valid && !was_pend && int'(wr_addr) < N) mbank[1 - mfront][wr_addr] = wr_color;
      if (commit && !was_pend) mpend = 1'b1;
      if (fstart) begin
        if (leddata_addr == 6'd0 && was_pend) begin
          mfront = 1 - mfront; mbright = int'(bright); mpend = 1'b0; exp_ack = 1'b1;
        end
        due_q.push_back(cyc + 2);
        val_q.push_back(int'(leddata_addr) < N ? scaled(mbank[mfront][leddata_addr], mbright) : 24'd0);
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        exp_color = val_q.pop_front();
        void'(due_q.pop_front());
      end
      mprev = leddata_start;
    end
    exp_ready = !mpend;
  end

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  initial begin : compare
    forever begin
      @(posedge clk); #1;
      if (checking) begin
        chk("color", leddata_color, exp_color);
        chk("wr_ready", 24'(wr_ready), 24'(exp_ready));
        chk("swap_ack", 24'(swap_ack), 24'(exp_ack));
        if (swap_ack) ack_cnt++;
      end
    end
  end

  task automatic write(input int a, input logic [23:0] c);
    @(negedge clk); wr_valid = 1'b1; wr_addr = 6'(a); wr_color = c;
    @(negedge clk); wr_valid = 1'b0;
  endtask

  task automatic commit_pulse();
    @(negedge clk); commit = 1'b1;
    @(negedge clk); commit = 1'b0;
  endtask

  task automatic fetch(input int a);
    @(negedge clk); leddata_addr = 6'(a); leddata_start = 1'b1;
    @(negedge clk); leddata_start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int a0;
    int changes;
    logic [23:0] prev;

    repeat (3) @(negedge clk);
    checking = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("reset_color", leddata_color, 24'h000000);
    chk("reset_ready", 24'(wr_ready), 24'd1);

    // Fill both banks so every later read is defined.
    for (int a = 0; a < N; a++) write(a, pat(1, a));
    commit_pulse();
    fetch(0);
    for (int a = 0; a < N; a++) write(a, pat(0, a));
    commit_pulse();
    fetch(0);

    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rst_color", leddata_color, 24'h000000);
    chk("rst_ack", 24'(swap_ack), 24'd0);
    rst = 1'b0;

    // Basic swap and two-cycle latency
    write(5, 24'h112233);
    commit_pulse();
    a0 = ack_cnt;
    fetch(0);
    chk("addr0_after_swap", leddata_color, pat(1, 0));
    @(negedge clk); leddata_addr = 6'd5; leddata_start = 1'b1;
    @(negedge clk); leddata_start = 1'b0;
    @(posedge clk); #1;
    chk("lat_t1", leddata_color, pat(1, 0));
    @(posedge clk); #1;
    chk("lat_t2", leddata_color, 24'h112233);
    chk("one_ack", 24'(ack_cnt - a0), 24'd1);

    // Brightness 127 sampled at swap
    bright = 8'd127;
    write(7, 24'hFF8040);
    commit_pulse();
    fetch(0);
    bright = 8'hFF;
    fetch(7);
    chk("bright127", leddata_color, 24'h7F4020);

    // Commit mid-frame: old bank until next frame start
    fetch(0);
    write(31, 24'h010203);
    for (int a = 1; a < 30; a++) fetch(a);
    commit_pulse();
    a0 = ack_cnt;
    for (int a = 30; a < N; a++) begin
      fetch(a);
      chk("ready_low_wait", 24'(wr_ready), 24'd0);
      if (a == 31) chk("old_bank_31", leddata_color, 24'h3E0F6E);
    end
    chk("no_early_swap", 24'(ack_cnt - a0), 24'd0);
    fetch(0);
    chk("late_swap", 24'(ack_cnt - a0), 24'd1);
    chk("ready_back", 24'(wr_ready), 24'd1);
    fetch(31);
    chk("new_bank_31", leddata_color, 24'h010203);

    // Write and commit on the same edge, then a redundant commit
    @(negedge clk); commit = 1'b1; wr_valid = 1'b1; wr_addr = 6'd63; wr_color = 24'hABCDEF;
    @(negedge clk); commit = 1'b0; wr_valid = 1'b0;
    commit_pulse();
    a0 = ack_cnt;
    fetch(0);
    fetch(63);
    repeat (3) @(negedge clk);
    chk("same_edge_write", leddata_color, 24'hABCDEF);
    chk("single_ack", 24'(ack_cnt - a0), 24'd1);

    // Held strobe starts exactly one fetch
    @(negedge clk); leddata_addr = 6'd10; leddata_start = 1'b1;
    prev = leddata_color;
    changes = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (leddata_color !== prev) changes++;
      prev = leddata_color;
    end
    @(negedge clk); leddata_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (leddata_color !== prev) changes++;
      prev = leddata_color;
    end
    chk("held_changes", 24'(changes), 24'd1);
    chk("held_color", leddata_color, 24'h290AC9);

    // Reset one cycle after a fetch start, while a swap is pending
    write(12, 24'h445566);
    commit_pulse();
    a0 = ack_cnt;
    @(negedge clk); leddata_addr = 6'd12; leddata_start = 1'b1;
    @(negedge clk); leddata_start = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_fetch_color", leddata_color, 24'h000000);
    chk("rst_drop_pending", 24'(wr_ready), 24'd1);
    repeat (4) @(negedge clk);
    chk("rst_color_hold", leddata_color, 24'h000000);
    fetch(0);
    chk("rst_no_ack", 24'(ack_cnt - a0), 24'd0);
    chk("rst_front0", leddata_color, 24'h0100C3);
    chk("total_acks", 24'(ack_cnt), 24'd6);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/my_ws2812_fb.md
MY_WS2812_FB -- requirements
Module: my_ws2812_fb

Interface
REQ-001 Parameter N_LEDS, default 64, is the number of LEDs per frame and the RAM depth per bank.
REQ-002 Parameter ADDR_W, default 6, is the LED address width, equal to clog2(N_LEDS).
REQ-003 Port clk  in  1  is the single clock; all logic is on its rising edge.
REQ-004 Port rst  in  1  is the reset, synchronous and active-high.
REQ-005 Port wr_valid  in  1  is the writer's request to store one LED color.
REQ-006 Port wr_ready  out  1  means a write is accepted on any edge where wr_valid && wr_ready.
REQ-007 Port wr_addr  in  ADDR_W  is the target LED index of the write.
REQ-008 Port wr_color  in  24  is the write color, GRB order, G in [23:16].
REQ-009 Port commit  in  1  is a one-cycle request to display the back bank from the next frame.
REQ-010 Port bright  in  8  is the global brightness, sampled at swap.
REQ-011 Port swap_ack  out  1  is a one-cycle pulse when a swap takes effect.
REQ-012 Port leddata_addr  in  ADDR_W  is the LED index requested by the ws2812 driver.
REQ-013 Port leddata_start  in  1  is the driver's fetch strobe; a fetch starts on its rising edge.
REQ-014 Port leddata_color  out  24  is the scaled GRB color returned to the driver.

Function
REQ-015 The block shall hold two banks of N_LEDS x 24 bits: front (read by the driver) and back (written by wr_*).
REQ-016 A write accepted at edge T shall be stored at back[wr_addr] and be readable after a swap at any edge later than T.
REQ-017 wr_ready shall be 1 whenever swap_pending is 0, and 0 while swap_pending is 1.
REQ-018 commit sampled high with swap_pending 0 shall set swap_pending; commit while pending shall be ignored.
REQ-019 When commit and an accepted write occur on the same edge, the write shall land in the back bank before the swap.
REQ-020 A fetch start is the first edge T where leddata_start is 1 and was 0 on the previous edge; a held-high strobe shall not start another fetch.
REQ-021 On a fetch start with leddata_addr == 0 and swap_pending 1, the front/back selection shall toggle, bright shall be latched into bright_r, and swap_pending shall clear.
REQ-022 The fetch in REQ-021 shall read the new front bank.
REQ-023 swap_ack shall be 1 for exactly the cycle following the swap edge.
REQ-024 Swaps shall occur only at frame start (address 0), so no frame mixes banks.
REQ-025 Read pipeline: edge T registers the address and bank, edge T+1 performs a registered RAM read, and edge T+2 updates leddata_color.
REQ-026 leddata_color shall hold its value until the next fetch's T+2 edge.
REQ-027 The T+2 latency fits within the driver's 28-cycle fetch window at CLK_SCALE 1.
REQ-028 Scaling shall be per channel: out = (ch * (bright_r + 1)) >> 8, a 9x8-bit product truncated to 8 bits.
REQ-029 Under REQ-028, bright_r 255 shall be the identity and bright_r 0 shall output ch >> 8, i.e. 0.
REQ-030 After a swap, the back bank shall hold the previously displayed frame, with no copy; the writer is responsible for rewriting it.
REQ-031 leddata_addr >= N_LEDS shall return 0 color; writes with wr_addr >= N_LEDS shall be accepted and discarded.

Reset
REQ-032 On rst, the block shall set: front = bank 0, swap_pending 0, wr_ready 1, swap_ack 0, bright_r 255, leddata_color 0, and the strobe edge-detect register to 0.
REQ-033 RAM contents shall not be cleared by rst.
REQ-034 rst during a fetch shall cancel that fetch, with leddata_color remaining 0.
REQ-035 rst during swap_pending shall drop the pending swap.

Structure
REQ-036 Package my_ws2812_pkg shall hold N_LEDS, ADDR_W, COLOR_W = 24, and the GRB field index constants, shared with my_ws2812.
REQ-037 Sub-module my_ws2812_fb_ram shall implement one bank: simple dual-port, one write port, one registered read port, instantiated twice.
REQ-038 The swap FSM, edge detect, and scaler shall live in the top module.

Verification
REQ-039 After rst, write addr 5 = 24'h112233 and commit, then fetch addr 0 followed by addr 5 with bright 255 -> swap_ack pulses once and addr 5 returns 24'h112233 exactly 2 cycles after its start edge.
REQ-040 With bright 127 sampled at swap, stored 24'hFF8040 -> returns 24'h7F4020.
REQ-041 Issue commit mid-frame at driver address 30 -> no swap until the next addr-0 fetch; addrs 31..63 return old-bank data; wr_ready is 0 throughout the wait.
REQ-042 Drive commit and wr_valid (addr 63, 24'hABCDEF) on the same edge -> after the swap, addr 63 returns 24'hABCDEF; a second commit while pending produces no extra swap_ack.
REQ-043 Hold leddata_start high for 10 cycles -> exactly one fetch and leddata_color changes only once.
REQ-044 Assert rst one cycle after a fetch start -> leddata_color is 0, swap_pending is 0, and no swap_ack pulse occurs.
